// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full adder, LSB first,
// with the carry held in a flop between bit positions.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic Sum,
    output logic Carry
);
    assign Sum   = a ^ b ^ c;
    assign Carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             load, last;
    logic             fa_sum, fa_carry;

    // The sum register's LSB is shifted out and never read back.
    logic s_sh_unused;
    assign s_sh_unused = s_sh[0];

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (carry),
        .Sum  (fa_sum),
        .Carry(fa_carry)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    last      = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (load) begin
                a_sh  <= a_in;
                b_sh  <= b_in;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
                carry <= fa_carry;
                a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                cnt   <= cnt + 1'b1;
            end
            if (last) begin
                sum_out <= {fa_sum, s_sh[WIDTH-1:1]};
                cout    <= fa_carry;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench: an 8-bit and a 4-bit instance checked
// against integer addition, latency and output-hold rules.
module tb_serial_add_ctrl;
    typedef struct {
        logic [32:0] v;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start [2];
    logic [31:0] ain   [2];
    logic [31:0] bin   [2];
    logic        cin   [2];
    logic        busy  [2];
    logic        done  [2];
    logic        cout  [2];
    logic [7:0]  s8;
    logic [3:0]  s4;

    exp_t        q     [2][$];
    logic [32:0] held  [2];
    logic [32:0] got;
    int          runlen[2];
    logic        rseen [2];
    int          cyc;
    int          ntests;
    int          nfail;
    exp_t        e;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start[0]),
        .a_in(ain[0][7:0]), .b_in(bin[0][7:0]), .cin(cin[0]),
        .busy(busy[0]), .done(done[0]), .sum_out(s8), .cout(cout[0])
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a_in(ain[1][3:0]), .b_in(bin[1][3:0]), .cin(cin[1]),
        .busy(busy[1]), .done(done[1]), .sum_out(s4), .cout(cout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wd(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic logic [32:0] getv(input int k);
        if (k == 0) return 33'({cout[0], s8});
        return 33'({cout[1], s4});
    endfunction

    task automatic chk(input string name, input int k,
                       input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s (w%0d) t=%0t: got %0h want %0h",
                     name, wd(k), $time, act, exp);
        end
    endtask

    // Monitor: pops expected results on every done pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            got = getv(k);
            if (rst) begin
                rseen[k]  = 1'b1;
                runlen[k] = 0;
                held[k]   = '0;
                q[k].delete();
            end else begin
                if (rseen[k]) begin
                    chk("reset_outputs", k,
                        64'({busy[k], done[k], got}), 64'd0);
                    rseen[k] = 1'b0;
                end
                chk("busy_done_excl", k, 64'(busy[k] & done[k]), 64'd0);
                if (busy[k]) runlen[k]++;
                if (done[k]) begin
                    chk("done_expected", k, 64'(q[k].size() != 0), 64'd1);
                    if (q[k].size() != 0) begin
                        e = q[k].pop_front();
                        chk("sum", k, 64'(got), 64'(e.v));
                        chk("latency", k, 64'(cyc - e.acc), 64'(wd(k)));
                    end
                    chk("busy_len", k, 64'(runlen[k]), 64'(wd(k)));
                    runlen[k] = 0;
                    held[k]   = got;
                end else begin
                    chk("hold", k, 64'(got), 64'(held[k]));
                    if (q[k].size() != 0 && cyc > q[k][0].acc + wd(k)) begin
                        chk("done_by_deadline", k, 64'(done[k]), 64'd1);
                        void'(q[k].pop_front());
                    end
                end
            end
        end
    end

    // Drives start for one edge; caller is aligned #1 after a posedge.
    task automatic issue(input int k, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        exp_t x;
        logic [32:0] m;
        m = (33'd1 << wd(k)) - 33'd1;
        a = a & m[31:0];
        b = b & m[31:0];
        ain[k]   = a;
        bin[k]   = b;
        cin[k]   = c;
        start[k] = 1'b1;
        x.v   = ({1'b0, a} + {1'b0, b} + 33'(c)) & ((m << 1) | 33'd1);
        x.acc = cyc + 1;
        q[k].push_back(x);
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        ain[k]   = $urandom;
        bin[k]   = $urandom;
        cin[k]   = 1'($urandom);
    endtask

    task automatic wait_done(input int k);
        for (int i = 0; i < wd(k) + 4; i++) begin
            @(posedge clk);
            #1;
            if (done[k]) break;
        end
    endtask

    task automatic op(input int k, input logic [31:0] a,
                      input logic [31:0] b, input logic c);
        issue(k, a, b, c);
        wait_done(k);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            ain[k]   = '0;
            bin[k]   = '0;
            cin[k]   = 1'b0;
            held[k]  = '0;
            runlen[k] = 0;
            rseen[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        op(0, 32'h5A, 32'h3C, 1'b0);
        op(0, 32'hFF, 32'h01, 1'b0);
        op(0, 32'hFF, 32'hFF, 1'b1);

        // start held during RUN must be ignored
        issue(0, 32'h10, 32'h20, 1'b0);
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        ain[0]   = 32'hAA;
        bin[0]   = 32'h55;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start[0] = 1'b0;
        wait_done(0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end

        // back-to-back accept in the DONE cycle
        issue(0, 32'h01, 32'h02, 1'b0);
        wait_done(0);
        issue(0, 32'h7F, 32'h01, 1'b0);
        wait_done(0);
        @(posedge clk);
        #1;

        // reset in RUN cycle 4 discards the operation
        issue(0, 32'hF0, 32'h0F, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        op(0, 32'h01, 32'h01, 1'b0);

        for (int n = 0; n < 60; n++) begin
            issue(0, $urandom, $urandom, 1'($urandom));
            wait_done(0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 512; i++) begin
            issue(1, 32'(i & 15), 32'((i >> 4) & 15), i[8]);
            wait_done(1);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (14) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition sequencer that shares one `full_adder` instance (ports `a`, `b`, `c`, `Sum`, `Carry`) across all bit positions of a WIDTH-bit add. It accepts an operand pair on a start handshake and feeds the adder LSB-first, one bit per clock, with the carry held in a flop between bits. It then presents the registered sum and carry-out with a one-cycle done pulse. It sits between a requesting controller and the single-bit adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2 to 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset; highest priority.
- `start` input 1: request; sampled only in IDLE or DONE.
- `a_in` input WIDTH: operand A, captured on the accepted start edge.
- `b_in` input WIDTH: operand B, captured on the accepted start edge.
- `cin` input 1: carry-in, captured on the accepted start edge.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; high exactly while in DONE.
- `sum_out` output WIDTH: result, registered, held until the next DONE.
- `cout` output 1: carry-out of the MSB, registered with `sum_out`.

## Operation
- States are IDLE, RUN and DONE. Encoding is free; there are no unreachable-state lockups, and an illegal state goes to IDLE.
- Internal registers:
  - `a_sh` and `b_sh`: operand shift registers, WIDTH bits each.
  - `s_sh`: sum shift register, WIDTH bits.
  - `carry`: 1 bit.
  - `cnt`: bit counter, width clog2(WIDTH+1).
- The adder inputs are `a_sh[0]`, `b_sh[0]` and `carry`. The adder is purely combinational, with no other drivers.
- IDLE with `start`=1 moves to RUN on that edge. On the same edge: `a_sh`<=`a_in`, `b_sh`<=`b_in`, `carry`<=`cin`, `cnt`<=0. With `start`=0, IDLE holds.
- RUN, on each edge:
  - `s_sh`<={`Sum`, `s_sh`[WIDTH-1:1]}.
  - `carry`<=`Carry`.
  - `a_sh` and `b_sh` shift right by one, zero-filled.
  - `cnt`<=`cnt`+1.
- RUN to DONE: taken on the edge where `cnt`==WIDTH-1. On that edge `sum_out`<={`Sum`, `s_sh`[WIDTH-1:1]} and `cout`<=`Carry`.
- DONE with `start`=1 moves to RUN, with the operand load as in IDLE (back-to-back accept). With `start`=0, DONE moves to IDLE.
- `start` while in RUN is ignored, not queued. Operand inputs are don't-care outside the accept edge.
- Arithmetic: {`cout`,`sum_out`} = `a_in` + `b_in` + `cin`, computed modulo 2^(WIDTH+1). There is no overflow flag; signed interpretation is the requester's job.
- `sum_out` and `cout` change only on the RUN to DONE edge (or on reset). They remain stable through the following IDLE and the next RUN.
- `rst`=1 on any edge:
  - State goes to IDLE.
  - `busy`, `done`, `sum_out` and `cout` are cleared to 0.
  - Internal registers are cleared.
  - An in-flight operation is discarded, with no done pulse.
  - A `start` in the same cycle as `rst` is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `sum_out`=0, `cout`=0, state IDLE.
- Accept edge E0: `busy` rises after E0.
- RUN lasts exactly WIDTH cycles, on edges E1..EWIDTH.
- `done`=1, `busy`=0 and the valid `sum_out`/`cout` appear after edge EWIDTH. Latency is WIDTH clocks from the accept edge.
- `done` is high for exactly one cycle. The next accept can happen on edge EWIDTH+1, giving a throughput of one add per WIDTH+1 clocks.
- `busy` and `done` are never high together. Both are registered outputs with no combinational input-to-output paths.

## Test plan
- Basic add, WIDTH=8: reset, then `start` with A=8'h5A, B=8'h3C, `cin`=0. Required: `busy` high for 8 cycles, then `done` pulses once, `sum_out`=8'h96, `cout`=0.
- Carry chain: A=8'hFF, B=8'h01, `cin`=0 gives `sum_out`=8'h00, `cout`=1. A=8'hFF, B=8'hFF, `cin`=1 gives `sum_out`=8'hFF, `cout`=1.
- Busy ignore: accept A=8'h10, B=8'h20. Hold `start`=1 with A=8'hAA, B=8'h55 during RUN cycles 2 to 5, then drop it before DONE. Required: a single `done`, `sum_out`=8'h30, and no second operation.
- Back-to-back: during the DONE cycle of 8'h01+8'h02, assert `start` with 8'h7F+8'h01. Required: 8'h03 appears first, RUN restarts immediately, and the second `done` comes 9 clocks after the first with `sum_out`=8'h80, `cout`=0.
- Reset mid-operation: assert `rst` for one cycle at RUN cycle 4 of 8'hF0+8'h0F. Required: all outputs 0 the next cycle, state IDLE, and no `done`. A following 8'h01+8'h01 yields 8'h02.
- Exhaustive: at WIDTH=4, all 512 {A,B,cin} combinations compared against a behavioural `+`, with `done` latency checked to be 4 clocks.
